// File: rtl/axi4_lite_slave_regfile_if.sv
// axi4_lite_slave_regfile_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels)
//   master modport: drives addresses, write data, VALIDs and BREADY/RREADY
//   slave modport : drives AWREADY/WREADY/ARREADY, B and R responses
interface axi4_lite_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile: AXI4-Lite slave backed by a NUM_REGS-word register file
//   aclk_i   : bus clock, rising edge
//   areset_i : synchronous active-high reset
//   bus      : AXI4-Lite slave modport; OKAY for idx < NUM_REGS, SLVERR otherwise
module axi4_lite_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input logic aclk_i,
    input logic areset_i,
    axi4_lite_slave_regfile_if.slave bus
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int XW = ADDR_WIDTH - 2;
    typedef enum logic [1:0] {W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    w_state_e              w_q, w_d;
    r_state_e              r_q, r_d;
    logic [XW-1:0]         waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  aw_hs, w_hs, ar_hs, commit, c_ok, r_ok;
    logic [XW-1:0]         c_idx, r_idx;
    logic [DATA_WIDTH-1:0] c_data;
    logic                  unused_low;

    assign unused_low  = ^{bus.awaddr[1:0], bus.araddr[1:0]};
    assign bus.awready = !areset_i && (w_q == W_IDLE || w_q == W_GOT_DATA);
    assign bus.wready  = !areset_i && (w_q == W_IDLE || w_q == W_GOT_ADDR);
    assign bus.bvalid  = !areset_i && w_q == W_RESP;
    assign bus.bresp   = bresp_q;
    assign bus.arready = !areset_i && r_q == R_IDLE;
    assign bus.rvalid  = !areset_i && r_q == R_DATA;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;

    // The completing handshake takes whichever half was not latched earlier from the bus.
    always_comb begin
        c_idx  = (w_q == W_GOT_ADDR) ? waddr_q : bus.awaddr[ADDR_WIDTH-1:2];
        c_data = (w_q == W_GOT_DATA) ? wdata_q : bus.wdata;
        c_ok   = c_idx < XW'(NUM_REGS);
        r_idx  = bus.araddr[ADDR_WIDTH-1:2];
        r_ok   = r_idx < XW'(NUM_REGS);
    end

    always_comb begin
        w_d     = w_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        bresp_d = bresp_q;
        commit  = 1'b0;
        case (w_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    w_d     = W_GOT_ADDR;
                    waddr_d = bus.awaddr[ADDR_WIDTH-1:2];
                end else if (w_hs) begin
                    w_d     = W_GOT_DATA;
                    wdata_d = bus.wdata;
                end
            end
            W_GOT_ADDR: commit = w_hs;
            W_GOT_DATA: commit = aw_hs;
            W_RESP:     w_d = bus.bready ? W_IDLE : W_RESP;
            default:    w_d = W_IDLE;
        endcase
        if (commit) begin
            w_d     = W_RESP;
            bresp_d = c_ok ? 2'b00 : 2'b10;
        end
    end

    // Read data is captured from regs_q before this edge's commit lands, so a
    // same-edge write to the same index returns the old value.
    always_comb begin
        r_d     = r_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        case (r_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_d     = R_DATA;
                    rdata_d = r_ok ? regs_q[r_idx[IW-1:0]] : '0;
                    rresp_d = r_ok ? 2'b00 : 2'b10;
                end
            end
            R_DATA:  r_d = bus.rready ? R_IDLE : R_DATA;
            default: r_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            w_q     <= W_IDLE;
            r_q     <= R_IDLE;
            waddr_q <= '0;
            wdata_q <= '0;
            bresp_q <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            w_q     <= w_d;
            r_q     <= r_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            bresp_q <= bresp_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            if (commit && c_ok) regs_q[c_idx[IW-1:0]] <= c_data;
        end
    end
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb_axi4_lite_slave_regfile: directed vector table plus hand sequences for the AXI4-Lite register file
module tb_axi4_lite_slave_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi4_lite_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    axi4_lite_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .aclk_i(clk),
        .areset_i(rst),
        .bus(bus)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        while (!(bus.awready && bus.wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_accept", 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("wr_bvalid_latency", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        while (!bus.arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept", 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        chk("rd_rvalid_latency", 32'(bus.rvalid), 32'd1);
        d    = bus.rdata;
        resp = bus.rresp;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 2'b00};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 2'b00};
        vecs[3]  = '{1'b1, 32'h0000_0040, 32'h0000_1234, 2'b10};
        vecs[4]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 2'b10};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h1111_1111, 2'b00};
        vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 2'b00};
        vecs[7]  = '{1'b1, 32'h0000_003C, 32'hA5A5_0001, 2'b00};
        vecs[8]  = '{1'b0, 32'h0000_003F, 32'hA5A5_0001, 2'b00};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 2'b10};
        vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 2'b10};
        vecs[11] = '{1'b0, 32'h0000_003C, 32'hA5A5_0001, 2'b00};
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rresp", 32'(bus.rresp), 32'd0);
        chk("rst_bresp", 32'(bus.bresp), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("post_rst_awready", 32'(bus.awready), 32'd1);
        rd(32'h4, d, r);
        chk("rst_read4_data", d, 32'd0);
        chk("rst_read4_resp", 32'(r), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].data, r);
                chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
            end else begin
                rd(vecs[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].data);
                chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
            end
        end

        // W leads AW by three cycles
        bus.wdata  = 32'h55AA_55AA;
        bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        repeat (3) begin
            chk("wlead_wready", 32'(bus.wready), 32'd0);
            chk("wlead_awready", 32'(bus.awready), 32'd1);
            chk("wlead_bvalid", 32'(bus.bvalid), 32'd0);
            @(negedge clk);
        end
        bus.awaddr  = 32'hC;
        bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        chk("wlead_bvalid_after_aw", 32'(bus.bvalid), 32'd1);
        chk("wlead_bresp", 32'(bus.bresp), 32'd0);
        @(negedge clk);
        rd(32'hC, d, r);
        chk("wlead_read_c", d, 32'h55AA_55AA);

        // read backpressure
        bus.araddr  = 32'h8;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        @(negedge clk);
        bus.arvalid = 1'b0;
        repeat (4) begin
            chk("rbp_rvalid", 32'(bus.rvalid), 32'd1);
            chk("rbp_rdata", bus.rdata, 32'hDEAD_BEEF);
            chk("rbp_arready", 32'(bus.arready), 32'd0);
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        chk("rbp_release_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rbp_release_arready", 32'(bus.arready), 32'd1);

        // write backpressure with an SLVERR response
        bus.bready  = 1'b0;
        bus.awaddr  = 32'h40;
        bus.wdata   = 32'h9;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        repeat (4) begin
            chk("wbp_bvalid", 32'(bus.bvalid), 32'd1);
            chk("wbp_bresp", 32'(bus.bresp), 32'd2);
            chk("wbp_awready", 32'(bus.awready), 32'd0);
            chk("wbp_wready", 32'(bus.wready), 32'd0);
            @(negedge clk);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        chk("wbp_release_bvalid", 32'(bus.bvalid), 32'd0);
        chk("wbp_release_awready", 32'(bus.awready), 32'd1);

        // same-edge write and read of index 2
        bus.awaddr  = 32'h8;
        bus.wdata   = 32'h1;
        bus.araddr  = 32'h8;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        chk("coll_rvalid", 32'(bus.rvalid), 32'd1);
        chk("coll_rdata_old", bus.rdata, 32'hDEAD_BEEF);
        chk("coll_bvalid", 32'(bus.bvalid), 32'd1);
        @(negedge clk);
        rd(32'h8, d, r);
        chk("coll_read_new", d, 32'h1);

        // reset while a write response is pending
        bus.bready  = 1'b0;
        bus.awaddr  = 32'h4;
        bus.wdata   = 32'h77;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("rstmid_bvalid_before", 32'(bus.bvalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_bvalid_after", 32'(bus.bvalid), 32'd0);
        chk("rstmid_awready", 32'(bus.awready), 32'd0);
        rst = 1'b0;
        bus.bready = 1'b1;
        @(negedge clk);
        chk("rstmid_bvalid_idle", 32'(bus.bvalid), 32'd0);
        rd(32'h8, d, r);
        chk("rstmid_read8", d, 32'd0);
        rd(32'h4, d, r);
        chk("rstmid_read4", d, 32'd0);
        rd(32'h3C, d, r);
        chk("rstmid_read3c", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
